// File: rtl/message_read_sched.sv
// Message read scheduler: fetches each stored message's start/end
// addresses from the location store and streams its byte addresses.
module message_read_sched #(
  parameter int DATA_WIDTH  = 5,
  parameter int NUM_MESSAGE = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  msg_done_i,
  input  logic [DATA_WIDTH-1:0] loc_data_i,
  input  logic                  addr_ready_i,
  output logic                  re_o,
  output logic                  read_start_o,
  output logic                  read_end_o,
  output logic [IDX_WIDTH-1:0]  read_index_o,
  output logic                  addr_valid_o,
  output logic [DATA_WIDTH-1:0] addr_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic [IDX_WIDTH:0]    pending_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    GET_START,
    GET_END,
    STREAM
  } state_t;

  localparam logic [IDX_WIDTH:0] FULL_CNT =
    (IDX_WIDTH+1)'(NUM_MESSAGE);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_MESSAGE - 1);

  state_t                state_q, state_d;
  logic [IDX_WIDTH:0]    pend_q, pend_d;
  logic [IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] end_q, end_d;
  logic                  first_q, first_d;
  logic                  endcap_q, endcap_d;
  logic                  ovf_q, ovf_d;
  logic                  last_beat;
  logic                  release_w;

  assign pending_o  = pend_q;
  assign full_o     = (pend_q == FULL_CNT);
  assign overflow_o = ovf_q;

  // Register bank for state, counters and captured addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      rd_idx_q <= '0;
      cur_q    <= '0;
      end_q    <= '0;
      first_q  <= 1'b0;
      endcap_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rd_idx_q <= rd_idx_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      first_q  <= first_d;
      endcap_q <= endcap_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, read requests and address stream generation
  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    cur_d        = cur_q;
    end_d        = end_q;
    first_d      = first_q;
    endcap_d     = endcap_q;
    re_o         = 1'b0;
    read_start_o = 1'b0;
    read_end_o   = 1'b0;
    read_index_o = '0;
    addr_valid_o = 1'b0;
    addr_o       = '0;
    sop_o        = 1'b0;
    eop_o        = 1'b0;
    last_beat    = 1'b0;
    release_w    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = GET_START;
      end
      GET_START: begin
        re_o         = 1'b1;
        read_start_o = 1'b1;
        read_index_o = rd_idx_q;
        state_d      = GET_END;
      end
      GET_END: begin
        re_o         = 1'b1;
        read_end_o   = 1'b1;
        read_index_o = rd_idx_q;
        // start data answers the GET_START request now
        cur_d        = loc_data_i;
        first_d      = 1'b1;
        endcap_d     = 1'b1;
        state_d      = STREAM;
      end
      STREAM: begin
        if (endcap_q) begin
          // end data answers the GET_END request now
          end_d    = loc_data_i;
          endcap_d = 1'b0;
        end else begin
          last_beat    = (cur_q == end_q);
          addr_valid_o = 1'b1;
          addr_o       = cur_q;
          sop_o        = first_q;
          eop_o        = last_beat;
          if (addr_ready_i) begin
            cur_d   = cur_q + 1'b1;
            first_d = 1'b0;
            if (last_beat) begin
              release_w = 1'b1;
              state_d   = IDLE;
              rd_idx_d  = (rd_idx_q == LAST_IDX) ?
                '0 : rd_idx_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending count and sticky overflow
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (msg_done_i && !release_w) begin
      if (full_o) ovf_d = 1'b1;
      else pend_d = pend_q + 1'b1;
    end else if (!msg_done_i && release_w) begin
      pend_d = pend_q - 1'b1;
    end
  end

endmodule

// File: doc/message_read_sched.md
MESSAGE_READ_SCHED -- requirements
Module: message_read_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 5, SHALL set the byte address width of the message buffer (depth 2^DATA_WIDTH).
REQ-002 Parameter NUM_MESSAGE, default 10, SHALL set the number of message location slots.
REQ-003 Parameter IDX_WIDTH, default 4, SHALL set the slot index width; it SHALL satisfy 2^IDX_WIDTH >= NUM_MESSAGE.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 msg_done_i  input  1  one-cycle pulse: one complete message's start and end addresses are stored.
REQ-008 loc_data_i  input  DATA_WIDTH  address returned by the location store.
REQ-009 addr_ready_i  input  1  downstream accepts addr_o.
REQ-010 re_o  output  1  location store read enable.
REQ-011 read_start_o  output  1  selects the start-address read.
REQ-012 read_end_o  output  1  selects the end-address read.
REQ-013 read_index_o  output  IDX_WIDTH  slot index being read.
REQ-014 addr_valid_o  output  1  addr_o is valid.
REQ-015 addr_o  output  DATA_WIDTH  buffer byte address to read.
REQ-016 sop_o  output  1  addr_o is the first byte of a message.
REQ-017 eop_o  output  1  addr_o is the last byte of a message.
REQ-018 pending_o  output  IDX_WIDTH+1  number of stored messages not yet streamed.
REQ-019 full_o  output  1  high when pending_o == NUM_MESSAGE.
REQ-020 overflow_o  output  1  sticky flag: msg_done_i arrived while full.

Function
REQ-021 The state machine SHALL have the states IDLE, GET_START, GET_END and STREAM, each held in a registered state.
REQ-022 IDLE: when pending > 0, go to GET_START; otherwise stay in IDLE.
REQ-023 GET_START: drive re_o=1, read_start_o=1, read_index_o=rd_idx for exactly one cycle, then go to GET_END.
REQ-024 loc_data_i SHALL be valid one cycle after the read request; the start address is captured on entry to GET_END.
REQ-025 GET_END: drive re_o=1, read_end_o=1, read_index_o=rd_idx for one cycle; the end address is captured the following cycle, and the block then enters STREAM.
REQ-026 read_start_o and read_end_o SHALL never be high together.
REQ-027 re_o SHALL be low outside GET_START and GET_END.
REQ-028 STREAM: addr_valid_o=1 and addr_o = current address, starting at the captured start address.
REQ-029 When addr_valid_o && addr_ready_i, the current address SHALL advance by 1 modulo 2^DATA_WIDTH.
REQ-030 addr_o, sop_o and eop_o SHALL hold stable while addr_valid_o && !addr_ready_i.
REQ-031 sop_o SHALL be high only on the first address of a message.
REQ-032 eop_o SHALL be high when the current address == the end address.
REQ-033 A message with end < start SHALL wrap through address 2^DATA_WIDTH-1 to 0.
REQ-034 A message with start == end SHALL be one beat, with sop_o=eop_o=1.
REQ-035 An accepted eop beat SHALL decrement pending, advance rd_idx (NUM_MESSAGE-1 wraps to 0) and go to IDLE.
REQ-036 The block SHALL return to IDLE with no idle cycle inserted between messages beyond that transition.
REQ-037 msg_done_i SHALL increment pending when not full.
REQ-038 msg_done_i together with an accepted eop beat SHALL leave pending unchanged.
REQ-039 msg_done_i while full (and no release in that cycle) SHALL not change pending, and SHALL set overflow_o.
REQ-040 pending SHALL never exceed NUM_MESSAGE or underflow.
REQ-041 full_o and pending_o SHALL be combinational from the pending register.

Reset
REQ-042 While rst=0, the block SHALL be forced to IDLE.
REQ-043 While rst=0, all of the following SHALL be 0: pending, rd_idx, captured addresses, overflow_o, re_o, read_start_o, read_end_o, addr_valid_o, sop_o, eop_o, addr_o, read_index_o, full_o.
REQ-044 Reset asserted mid-message SHALL abandon the message; after deassertion the block SHALL stay idle until a new msg_done_i arrives.
REQ-045 overflow_o SHALL clear only on reset.

Verification
REQ-046 One message with start=3, end=6 and addr_ready_i=1 -> read_start at idx 0, then read_end, then addresses 3,4,5,6; sop on 3, eop on 6; pending goes 1 then 0.
REQ-047 Wrap: start=30, end=1 -> addresses 30,31,0,1; eop on 1.
REQ-048 Backpressure: addr_ready_i low for 3 cycles mid-stream -> addr_o and flags hold, and no beat is skipped or repeated.
REQ-049 11 msg_done_i pulses with no drain -> pending=10, full_o=1, overflow_o=1.
REQ-050 Draining the full store -> indices 0..9 are read, then the index wraps to 0.
REQ-051 msg_done_i in the same cycle as an accepted eop beat -> pending unchanged.
REQ-052 start == end -> a single beat with sop_o=eop_o=1.
REQ-053 rst low during STREAM -> all outputs are 0 at once and the state is IDLE, with pending=0.
